ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter addrBits, default 8, RAM word-address width.
REQ-002 SHALL have parameter dataBits, default 16, RAM word width.
REQ-003 SHALL have parameter maxBurst, default 4, max consecutive grants to one requester while the other waits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  input  1  requester 0/1 access request; held high until ack.
REQ-007 write0 / write1  input  1  1 = write, 0 = read, valid with req.
REQ-008 addr0 / addr1  input  addrBits  word address, valid with req.
REQ-009 wdata0 / wdata1  input  dataBits  write data, valid with req and write.
REQ-010 ack0 / ack1  output  1  combinational grant; access issued to RAM this cycle.
REQ-011 rdValid0 / rdValid1  output  1  registered; read data for this requester present this cycle.
REQ-012 rdata  output  dataBits  RAM read data; meaningful only when a rdValid is high.
REQ-013 initDone  output  1  registered; high once post-reset clear sweep is complete.

Function
REQ-014 SHALL own exactly one single-port RAM instance (addrBits x dataBits, 1-cycle registered read); every access goes through this block.
REQ-015 FSM states SHALL be INIT, OWN0, OWN1; OWNi = requester i served most recently.
REQ-016 INIT: counter clearAddr steps 0..2^addrBits-1, one zero-write per cycle; ack0=ack1=0; after the last address is written, next state OWN1, initDone=1.
REQ-017 At most one ack SHALL be high per cycle; no ack in INIT.
REQ-018 One requester asserting req in OWN0/OWN1: that requester SHALL get ack the same cycle.
REQ-019 Both requesting, burstCount < maxBurst: current owner SHALL keep ack; burstCount increments.
REQ-020 Both requesting, burstCount == maxBurst: ack SHALL go to the other requester; state switches; burstCount = 1.
REQ-021 Ownership change for any reason SHALL set burstCount = 1; no request leaves state and burstCount unchanged.
REQ-022 On ack, RAM address, write-enable and data SHALL be the acked requester's, captured at the closing edge of that cycle.
REQ-023 Read acked in cycle N SHALL give rdValidi=1 and rdata = RAM[addr] in cycle N+1 only; write ack SHALL give no rdValid.
REQ-024 Back-to-back acks SHALL sustain one access per cycle; read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-025 req deasserted without ack SHALL leave no side effect.

Reset
REQ-026 resetN low SHALL immediately force state INIT, clearAddr=0, burstCount=0, initDone=0, rdValid0=rdValid1=0, regardless of clk.
REQ-027 Reset mid-access or mid-sweep SHALL discard the pending read and restart the full clear sweep after release.
REQ-028 rdata SHALL be don't-care during and after reset until the first rdValid.

Structure
REQ-029 RAM_WRITE/RAM_READ encodings and FSM state encodings SHALL live in the shared defaults header; no local redefinition.
REQ-030 The RAM SHALL be the existing single-port BRAM wrapper, instantiated once as the only sub-module; arbitration and sweep logic in this module.

Verification
REQ-031 Release reset; no requests -> initDone rises after exactly 256 cycles; reading every address returns 0x0000.
REQ-032 After init, req0 writes 0xBEEF to 0x12; next cycle req1 reads 0x12 -> ack1 that cycle, rdValid1=1 and rdata=0xBEEF next cycle.
REQ-033 Both req held continuously from OWN1 -> ack sequence 0,0,0,0,1,1,1,1,0... (maxBurst=4), never both acks high.
REQ-034 req0 held, req1 pulses once for one cycle at burstCount=2 -> ack stays on 0, no access for requester 1, RAM unchanged.
REQ-035 resetN low during a read-ack cycle and during sweep address 0x80 -> rdValid never asserts; initDone=0; full 256-cycle sweep repeats.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: RAM access direction and arbiter FSM states.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    function automatic arb_state_e owner_state(input logic sel1);
        if (sel1) begin
            return ST_OWN1;
        end else begin
            return ST_OWN0;
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_bram.sv
// Single-port block RAM wrapper with a one-cycle registered read port.
module ram_arbiter_bram
    import ram_arbiter_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [addrBits-1:0] i_addr,
    input  logic [dataBits-1:0] i_wdata,
    output logic [dataBits-1:0] o_rdata
);

    logic [dataBits-1:0] r_mem [0:(1 << addrBits)-1];
    logic [dataBits-1:0] r_rdata;

    // Storage array and read register; read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we == RAM_WRITE) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one single-port RAM, with a post-reset
// zero-clear sweep and bounded-burst fairness between the requesters.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int dataBits = 16,
    parameter int maxBurst = 4
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                req0,
    input  logic                req1,
    input  logic                write0,
    input  logic                write1,
    input  logic [addrBits-1:0] addr0,
    input  logic [addrBits-1:0] addr1,
    input  logic [dataBits-1:0] wdata0,
    input  logic [dataBits-1:0] wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic                rdValid0,
    output logic                rdValid1,
    output logic [dataBits-1:0] rdata,
    output logic                initDone
);

    localparam int                  BURST_W   = $clog2(maxBurst + 1);
    localparam logic [BURST_W-1:0]  BURST_MAX = BURST_W'(maxBurst);
    localparam logic [BURST_W-1:0]  BURST_ONE = BURST_W'(1'b1);
    localparam logic [BURST_W-1:0]  BURST_ZERO = {BURST_W{1'b0}};
    localparam logic [addrBits-1:0] ADDR_ONE  = addrBits'(1'b1);
    localparam logic [addrBits-1:0] ADDR_LAST = {addrBits{1'b1}};

    arb_state_e          r_state;
    logic [addrBits-1:0] r_clear_addr;
    logic [BURST_W-1:0]  r_burst;
    logic                r_init_done;
    logic                r_rd_valid0;
    logic                r_rd_valid1;

    arb_state_e          w_next_state;
    logic [addrBits-1:0] w_next_clear_addr;
    logic [BURST_W-1:0]  w_next_burst;
    logic                w_next_init_done;
    logic                w_owner1;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_ram_we;
    logic [addrBits-1:0] w_ram_addr;
    logic [dataBits-1:0] w_ram_wdata;
    logic [dataBits-1:0] w_ram_rdata;

    assign w_owner1 = (r_state == ST_OWN1);

    // Next-state, grant and RAM-port selection.
    always_comb begin
        w_next_state      = r_state;
        w_next_clear_addr = r_clear_addr;
        w_next_burst      = r_burst;
        w_next_init_done  = r_init_done;
        w_grant0          = 1'b0;
        w_grant1          = 1'b0;
        w_ram_we          = RAM_READ;
        w_ram_addr        = {addrBits{1'b0}};
        w_ram_wdata       = {dataBits{1'b0}};

        case (r_state)
            ST_INIT: begin
                w_ram_we          = RAM_WRITE;
                w_ram_addr        = r_clear_addr;
                w_next_clear_addr = r_clear_addr + ADDR_ONE;
                // Leaving with a spent burst makes requester 0 win the first contention.
                if (r_clear_addr == ADDR_LAST) begin
                    w_next_state     = ST_OWN1;
                    w_next_burst     = BURST_MAX;
                    w_next_init_done = 1'b1;
                end else begin
                    w_next_state     = ST_INIT;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (req0 && req1) begin
                    if (r_burst >= BURST_MAX) begin
                        w_grant1 = ~w_owner1;
                    end else begin
                        w_grant1 = w_owner1;
                    end
                    w_grant0 = ~w_grant1;
                end else begin
                    w_grant0 = req0;
                    w_grant1 = req1;
                end

                if (w_grant0 || w_grant1) begin
                    if (w_grant1 == w_owner1) begin
                        w_next_burst = (r_burst >= BURST_MAX) ? BURST_MAX : (r_burst + BURST_ONE);
                    end else begin
                        w_next_burst = BURST_ONE;
                        w_next_state = owner_state(w_grant1);
                    end
                end else begin
                    w_next_burst = r_burst;
                end

                if (w_grant1) begin
                    w_ram_we    = write1 ? RAM_WRITE : RAM_READ;
                    w_ram_addr  = addr1;
                    w_ram_wdata = wdata1;
                end else if (w_grant0) begin
                    w_ram_we    = write0 ? RAM_WRITE : RAM_READ;
                    w_ram_addr  = addr0;
                    w_ram_wdata = wdata0;
                end else begin
                    w_ram_we    = RAM_READ;
                end
            end
            default: begin
                w_next_state      = ST_INIT;
                w_next_clear_addr = {addrBits{1'b0}};
                w_next_burst      = BURST_ZERO;
                w_next_init_done  = 1'b0;
            end
        endcase
    end

    // State, sweep counter, burst counter and read-valid registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_INIT;
            r_clear_addr <= {addrBits{1'b0}};
            r_burst      <= BURST_ZERO;
            r_init_done  <= 1'b0;
            r_rd_valid0  <= 1'b0;
            r_rd_valid1  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_clear_addr <= w_next_clear_addr;
            r_burst      <= w_next_burst;
            r_init_done  <= w_next_init_done;
            r_rd_valid0  <= w_grant0 && (write0 == RAM_READ);
            r_rd_valid1  <= w_grant1 && (write1 == RAM_READ);
        end
    end

    ram_arbiter_bram #(
        .addrBits (addrBits),
        .dataBits (dataBits)
    ) u_bram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign ack0     = w_grant0;
    assign ack1     = w_grant1;
    assign rdValid0 = r_rd_valid0;
    assign rdValid1 = r_rd_valid1;
    assign rdata    = w_ram_rdata;
    assign initDone = r_init_done;

endmodule
